// File: rtl/mem_access_unit.sv
// Memory access unit: MAR/MDR registers plus a two-state request/acknowledge sequencer.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] buso,
    input  logic              mari,
    input  logic              mdri,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] busi_mdr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef MEM_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic              we_r;
    logic              done_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt;
    logic              start;
    logic              ack_hit;
    logic              timeout_hit;

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // An acknowledge on the terminal count still counts as a normal completion.
                if (mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            mar    <= '0;
            mdr    <= '0;
            we_r   <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            cnt    <= '0;
        end else begin
            done_r <= ack_hit || timeout_hit;
            if (start) begin
                we_r  <= ~mem_read;
                err_r <= 1'b0;
                cnt   <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout_hit) begin
                err_r <= 1'b1;
            end
            // MAR/MDR only follow the bus while idle so the access sees stable values.
            if (state == IDLE) begin
                if (mari) mar <= buso[ADDR_W-1:0];
                if (mdri) mdr <= buso;
            end else if (ack_hit && !we_r) begin
                mdr <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state == ACCESS);
    assign busy      = (state == ACCESS);
    assign mem_we    = we_r;
    assign done      = done_r;
    assign err       = TIMEOUT_EN ? err_r : 1'b0;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign busi_mdr  = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; completions are checked against a scoreboard
// of expected MDR/err values pushed when each access is started.
module tb_mem_access_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    logic              clock = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] buso = '0;
    logic              mari = 1'b0;
    logic              mdri = 1'b0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] busi_mdr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_req;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct {
        logic [DATA_W-1:0] mdr;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(15)) dut (
        .clock(clock), .clear(clear), .buso(buso), .mari(mari), .mdri(mdri),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busi_mdr(busi_mdr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] m, input logic e);
        exp_t x;
        x.mdr = m;
        x.err = e;
        sb.push_back(x);
    endtask

    // Completion monitor: every done pulse must match the oldest expected entry.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_mdr", 64'(busi_mdr), 64'(e.mdr));
                chk("sb_err", 64'(err), 64'(e.err));
            end
        end
    end

    initial begin
        int req_cycles;

        // Reset
        clear = 1'b1;
        buso = 32'hFFFF_FFFF; mari = 1'b1; mdri = 1'b1; mem_read = 1'b1;
        step(); step();
        clear = 1'b0; mari = 1'b0; mdri = 1'b0; mem_read = 1'b0; buso = '0;
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_mdr", 64'(busi_mdr), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);

        // Read with ack on the third access edge; upper MAR bits discarded
        buso = 32'hFFFF_F1F5; mari = 1'b1;
        step();
        mari = 1'b0;
        chk("rd_addr", 64'(mem_addr), 64'h1F5);
        mem_read = 1'b1;
        push_exp(32'hDEAD_BEEF, 1'b0);
        step();
        mem_read = 1'b0;
        req_cycles = 0;
        chk("rd_we", 64'(mem_we), 64'd0);
        chk("rd_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
            step();
        end
        mem_ack = 1'b0;
        chk("rd_req_cycles", 64'(req_cycles), 64'd3);
        chk("rd_req_low", 64'(mem_req), 64'd0);
        chk("rd_done", 64'(done), 64'd1);
        chk("rd_mdr", 64'(busi_mdr), 64'hDEAD_BEEF);
        step();
        chk("rd_done_1cyc", 64'(done), 64'd0);

        // Write, MDR loaded on the start edge itself, ack in the first cycle
        buso = 32'h0000_0010; mari = 1'b1;
        step();
        mari = 1'b0;
        buso = 32'h1234_5678; mdri = 1'b1; mem_write = 1'b1;
        push_exp(32'h1234_5678, 1'b0);
        step();
        mdri = 1'b0; mem_write = 1'b0;
        chk("wr_we", 64'(mem_we), 64'd1);
        chk("wr_wdata", 64'(mem_wdata), 64'h1234_5678);
        chk("wr_addr", 64'(mem_addr), 64'h010);
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        step();
        mem_ack = 1'b0;
        chk("wr_done", 64'(done), 64'd1);
        chk("wr_mdr_kept", 64'(busi_mdr), 64'h1234_5678);
        step();

        // Busy masking: loads and a new start during ACCESS are ignored
        mem_read = 1'b1;
        push_exp(32'h0BAD_F00D, 1'b0);
        step();
        mem_read = 1'b0;
        buso = 32'hAAAA_5555; mdri = 1'b1; mari = 1'b1; mem_write = 1'b1;
        step();
        mdri = 1'b0; mari = 1'b0; mem_write = 1'b0;
        chk("mask_mdr", 64'(busi_mdr), 64'h1234_5678);
        chk("mask_addr", 64'(mem_addr), 64'h010);
        chk("mask_we", 64'(mem_we), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        chk("mask_rdata", 64'(busi_mdr), 64'h0BAD_F00D);
        step();
        chk("mask_no_2nd", 64'(mem_req), 64'd0);

        // Ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_req", 64'(mem_req), 64'd0);
        chk("idle_ack_mdr", 64'(busi_mdr), 64'h0BAD_F00D);

        // Collision: read wins
        mem_read = 1'b1; mem_write = 1'b1;
        push_exp(32'h0000_0055, 1'b0);
        step();
        mem_read = 1'b0; mem_write = 1'b0;
        chk("coll_we", 64'(mem_we), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        step();
        mem_ack = 1'b0;
        step();

        // Clear mid-ACCESS aborts with no done
        buso = 32'h0000_01AB; mari = 1'b1; mdri = 1'b1; mem_write = 1'b1;
        step();
        mari = 1'b0; mdri = 1'b0; mem_write = 1'b0;
        chk("abort_we", 64'(mem_we), 64'd1);
        step();
        clear = 1'b1; mem_ack = 1'b1;
        step();
        clear = 1'b0; mem_ack = 1'b0;
        chk("abort_req", 64'(mem_req), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_mdr", 64'(busi_mdr), 64'd0);
        chk("abort_addr", 64'(mem_addr), 64'd0);
        chk("abort_we0", 64'(mem_we), 64'd0);
        step();
        chk("abort_done_later", 64'(done), 64'd0);

`ifdef MEM_TIMEOUT_EN
        // Never acknowledged: times out after 15 cycles
        buso = 32'h0000_0077; mdri = 1'b1;
        step();
        mdri = 1'b0;
        mem_read = 1'b1;
        push_exp(32'h0000_0077, 1'b1);
        step();
        mem_read = 1'b0;
        req_cycles = 0;
        while (mem_req === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            step();
        end
        chk("to_req_cycles", 64'(req_cycles), 64'd15);
        chk("to_err", 64'(err), 64'd1);
        chk("to_done", 64'(done), 64'd1);
        chk("to_mdr_kept", 64'(busi_mdr), 64'h77);
        step();
        chk("to_err_sticky", 64'(err), 64'd1);

        // Next start clears err
        mem_read = 1'b1;
        push_exp(32'hC0DE_0001, 1'b0);
        step();
        mem_read = 1'b0;
        chk("to_err_clr", 64'(err), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'hC0DE_0001;
        step();
        mem_ack = 1'b0;
        step();

        // Ack on the terminal cycle wins
        mem_read = 1'b1;
        push_exp(32'hC0DE_0015, 1'b0);
        step();
        mem_read = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("term_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b1; mem_rdata = 32'hC0DE_0015;
        step();
        mem_ack = 1'b0;
        chk("term_done", 64'(done), 64'd1);
        chk("term_err", 64'(err), 64'd0);
        chk("term_mdr", 64'(busi_mdr), 64'hC0DE_0015);
        step();
`else
        // Without the timeout an access waits indefinitely and err stays 0
        mem_read = 1'b1;
        push_exp(32'hC0DE_0040, 1'b0);
        step();
        mem_read = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("wait_req", 64'(mem_req), 64'd1);
        chk("wait_err", 64'(err), 64'd0);
        chk("wait_done", 64'(done), 64'd0);
        mem_ack = 1'b1; mem_rdata = 32'hC0DE_0040;
        step();
        mem_ack = 1'b0;
        chk("wait_fin", 64'(done), 64'd1);
        step();
`endif

        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
